// File: rtl/mem_b_arbiter_pkg.sv
// Shared types and constants for the memory port-B arbiter.
`default_nettype none

package mem_b_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DISP  = 2'd1,
    ST_DBG   = 2'd2,
    ST_FORCE = 2'd3
  } arb_state_e;

  typedef enum logic [0:0] {
    ID_DISP = 1'b0,
    ID_DBG  = 1'b1
  } req_id_e;

  localparam int MEM_B_LATENCY = 3;
  localparam int WAIT_CNT_W    = 5;

endpackage

`default_nettype wire

// File: rtl/mem_b_tag_pipe.sv
// Shift pipeline of (valid, id) tags that follows each read through the memory port.
`default_nettype none

module mem_b_tag_pipe #(
  parameter int DEPTH = 3,
  parameter int ID_W  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic [ID_W-1:0] id_i,
  output logic            valid_o,
  output logic [ID_W-1:0] id_o
);

  logic [DEPTH-1:0]           vld_q;
  logic [DEPTH-1:0][ID_W-1:0] id_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q <= {vld_q[DEPTH-2:0], push_i};
      id_q  <= {id_q[DEPTH-2:0], id_i};
    end
  end

  assign valid_o = vld_q[DEPTH-1];
  assign id_o    = id_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/mem_b_arbiter.sv
// Two-requester arbiter for memory port B: display has priority, debug gets a
// forced grant after MAX_WAIT consecutive denied cycles. Fixed 3-cycle read latency.
`default_nettype none

module mem_b_arbiter
  import mem_b_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 24,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] read_data_b,
  output logic              dbg_starved
);

  localparam int                    ID_W       = $bits(req_id_e);
  localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_C = WAIT_CNT_W'(MAX_WAIT);

  arb_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]     address_b_q;
  req_id_e               tag_id_in;
  logic                  tag_valid;
  logic [ID_W-1:0]       tag_id_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Grants are decided combinationally from this cycle's requests; rst low masks them.
  always_comb begin
    state_d     = ST_IDLE;
    disp_gnt    = 1'b0;
    dbg_gnt     = 1'b0;
    dbg_starved = 1'b0;
    wait_cnt_d  = wait_cnt_q;
    if (rst) begin
      if (dbg_req && (wait_cnt_q == MAX_WAIT_C)) state_d = ST_FORCE;
      else if (disp_req)                         state_d = ST_DISP;
      else if (dbg_req)                          state_d = ST_DBG;
    end
    case (state_d)
      ST_DISP:  disp_gnt = 1'b1;
      ST_DBG:   dbg_gnt  = 1'b1;
      ST_FORCE: begin
        dbg_gnt     = 1'b1;
        dbg_starved = 1'b1;
      end
      default: ;
    endcase
    if (!dbg_req || dbg_gnt)           wait_cnt_d = '0;
    else if (wait_cnt_q != MAX_WAIT_C) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      address_b_q <= '0;
    end else if (disp_gnt || dbg_gnt) begin
      address_b_q <= dbg_gnt ? dbg_addr : disp_addr;
    end
  end

  assign address_b = address_b_q;
  assign tag_id_in = dbg_gnt ? ID_DBG : ID_DISP;

  mem_b_tag_pipe #(
    .DEPTH (MEM_B_LATENCY),
    .ID_W  (ID_W)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .push_i  (disp_gnt || dbg_gnt),
    .id_i    (tag_id_in),
    .valid_o (tag_valid),
    .id_o    (tag_id_out)
  );

  assign disp_rvalid = tag_valid && (tag_id_out == ID_DISP);
  assign dbg_rvalid  = tag_valid && (tag_id_out == ID_DBG);
  assign disp_rdata  = disp_rvalid ? read_data_b : '0;
  assign dbg_rdata   = dbg_rvalid  ? read_data_b : '0;

  // A forced grant always restarts the starvation count.
  a_force_clears_wait: assert property (
    @(posedge clk) disable iff (!rst) (state_q == ST_FORCE) |-> (wait_cnt_q == '0)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_b_arbiter.sv
// Bench for mem_b_arbiter: spec-level reference model checked every cycle plus literal pins.
`default_nettype none

module tb_mem_b_arbiter;

  localparam int ADDR_W   = 18;
  localparam int DATA_W   = 24;
  localparam int MAX_WAIT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              disp_req, dbg_req;
  logic [ADDR_W-1:0] disp_addr, dbg_addr;
  logic              disp_gnt, dbg_gnt, disp_rvalid, dbg_rvalid, dbg_starved;
  logic [DATA_W-1:0] disp_rdata, dbg_rdata, read_data_b;
  logic [ADDR_W-1:0] address_b;
  logic [DATA_W-1:0] mem_s1, mem_s2;

  mem_b_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .address_b(address_b), .read_data_b(read_data_b), .dbg_starved(dbg_starved)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] memf(input logic [ADDR_W-1:0] a);
    return {6'b0, a} ^ 24'h5A5A5A;
  endfunction

  // Memory stage: two registers after the address register.
  always @(posedge clk) begin
    mem_s1 <= memf(address_b);
    mem_s2 <= mem_s1;
  end
  assign read_data_b = mem_s2;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  typedef struct {
    int                due;
    bit                is_dbg;
    logic [ADDR_W-1:0] addr;
  } pend_t;

  pend_t             pend[$];
  int                cyc = 0;
  int                m_wait = 0;
  logic [ADDR_W-1:0] m_addr = '0;

  int                n_disp_gnt = 0, n_dbg_gnt = 0, n_starved = 0;
  int                n_disp_rv = 0, n_dbg_rv = 0, last_starve_cyc = -1;
  logic [DATA_W-1:0] last_disp_rdata = '0, last_dbg_rdata = '0;

  // Reference model: decides grants from requests and the starvation count,
  // and schedules each granted read to return three cycles later.
  always @(negedge clk) begin
    bit                e_dgnt, e_bgnt, e_force, e_drv, e_brv;
    logic [DATA_W-1:0] e_ddata, e_bdata;
    e_dgnt = 0; e_bgnt = 0; e_force = 0; e_drv = 0; e_brv = 0;
    e_ddata = '0; e_bdata = '0;
    if (!rst) begin
      pend.delete();
      m_wait = 0;
      m_addr = '0;
    end else begin
      e_force = dbg_req && (m_wait == MAX_WAIT);
      e_bgnt  = dbg_req && (e_force || !disp_req);
      e_dgnt  = disp_req && !e_bgnt;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        if (pend[0].is_dbg) begin e_brv = 1; e_bdata = memf(pend[0].addr); end
        else                begin e_drv = 1; e_ddata = memf(pend[0].addr); end
        void'(pend.pop_front());
      end
    end
    chk("disp_gnt", 32'(disp_gnt), 32'(e_dgnt));
    chk("dbg_gnt", 32'(dbg_gnt), 32'(e_bgnt));
    chk("dbg_starved", 32'(dbg_starved), 32'(e_force));
    chk("disp_rvalid", 32'(disp_rvalid), 32'(e_drv));
    chk("dbg_rvalid", 32'(dbg_rvalid), 32'(e_brv));
    chk("disp_rdata", 32'(disp_rdata), 32'(e_ddata));
    chk("dbg_rdata", 32'(dbg_rdata), 32'(e_bdata));
    chk("address_b", 32'(address_b), 32'(m_addr));
    if (rst) begin
      if (e_bgnt || e_dgnt) begin
        pend.push_back('{due: cyc + 3, is_dbg: e_bgnt, addr: e_bgnt ? dbg_addr : disp_addr});
        m_addr = e_bgnt ? dbg_addr : disp_addr;
      end
      if (dbg_req && !e_bgnt) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      else                    m_wait = 0;
    end
    if (disp_gnt)    n_disp_gnt++;
    if (dbg_gnt)     n_dbg_gnt++;
    if (dbg_starved) begin n_starved++; last_starve_cyc = cyc; end
    if (disp_rvalid) begin n_disp_rv++; last_disp_rdata = disp_rdata; end
    if (dbg_rvalid)  begin n_dbg_rv++;  last_dbg_rdata  = dbg_rdata;  end
    cyc++;
  end

  task automatic step(input logic dr, input logic [ADDR_W-1:0] da,
                      input logic br, input logic [ADDR_W-1:0] ba);
    disp_req = dr; disp_addr = da; dbg_req = br; dbg_addr = ba;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0);
  endtask

  initial begin
    int b_dg, b_bg, b_st, b_drv, b_brv, t0;
    rst = 1'b0; disp_req = 0; dbg_req = 0; disp_addr = '0; dbg_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_address_b", 32'(address_b), 32'h0);
    chk("reset_gnt", {30'b0, disp_gnt, dbg_gnt}, 32'h0);
    rst = 1'b1;

    // Display only, addresses 0..4.
    b_dg = n_disp_gnt; b_drv = n_disp_rv;
    for (int i = 0; i < 5; i++) step(1, ADDR_W'(i), 0, '0);
    idle(6);
    chk("disp_only_gnts", 32'(n_disp_gnt - b_dg), 32'd5);
    chk("disp_only_rvs", 32'(n_disp_rv - b_drv), 32'd5);
    chk("disp_only_last_data", 32'(last_disp_rdata), 32'h5A5A5E);

    // Both requesting continuously: 16 display grants, then a forced debug grant.
    b_bg = n_dbg_gnt; b_st = n_starved; t0 = cyc;
    for (int i = 0; i < 17; i++) step(1, ADDR_W'(i), 1, ADDR_W'(200 + i));
    chk("first_force_cycle", 32'(last_starve_cyc - t0), 32'd16);
    for (int i = 17; i < 34; i++) step(1, ADDR_W'(i), 1, ADDR_W'(200 + i));
    chk("second_force_cycle", 32'(last_starve_cyc - t0), 32'd33);
    chk("starve_pulses", 32'(n_starved - b_st), 32'd2);
    chk("starve_dbg_gnts", 32'(n_dbg_gnt - b_bg), 32'd2);
    idle(6);

    // Alternating display/debug, back to back.
    b_drv = n_disp_rv; b_brv = n_dbg_rv;
    for (int i = 0; i < 3; i++) begin
      step(1, ADDR_W'(100), 0, '0);
      step(0, '0, 1, ADDR_W'(90500));
    end
    idle(6);
    chk("alt_disp_rvs", 32'(n_disp_rv - b_drv), 32'd3);
    chk("alt_dbg_rvs", 32'(n_dbg_rv - b_brv), 32'd3);
    chk("alt_disp_data", 32'(last_disp_rdata), 32'h5A5A3E);
    chk("alt_dbg_data", 32'(last_dbg_rdata), 32'h5B3BDE);

    // Reset while a read is in flight: it must vanish.
    b_drv = n_disp_rv;
    step(1, ADDR_W'(7), 0, '0);
    rst = 1'b0;
    #1;
    chk("rst_mid_address_b", 32'(address_b), 32'h0);
    step(0, '0, 0, '0);
    step(0, '0, 0, '0);
    rst = 1'b1;
    step(1, ADDR_W'(9), 0, '0);
    idle(6);
    chk("rst_drop_rvs", 32'(n_disp_rv - b_drv), 32'd1);
    chk("rst_new_data", 32'(last_disp_rdata), 32'h5A5A53);

    // Short debug pulse under display load: no forced grant, counter restarts.
    b_bg = n_dbg_gnt; b_st = n_starved;
    step(1, ADDR_W'(1), 0, '0);
    for (int i = 0; i < 3; i++) step(1, ADDR_W'(2), 1, ADDR_W'(3));
    step(1, ADDR_W'(4), 0, '0);
    chk("pulse_no_starve", 32'(n_starved - b_st), 32'd0);
    chk("pulse_no_dbg_gnt", 32'(n_dbg_gnt - b_bg), 32'd0);
    t0 = cyc;
    for (int i = 0; i < 17; i++) step(1, ADDR_W'(5), 1, ADDR_W'(6));
    chk("pulse_counter_restart", 32'(last_starve_cyc - t0), 32'd16);
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
